// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared types and constants for the I2C target/controller
// Purpose: state encoding for the I2C target FSM, R/W bit polarity and byte width.
// Ports: none (package).
package i2c_pkg;

  localparam int   I2C_BYTE_W  = 8;
  localparam logic I2C_RW_READ = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ACK_ADDR,
    ST_RX_BYTE,
    ST_ACK_RX,
    ST_TX_BYTE,
    ST_WAIT_MACK,
    ST_IGNORE
  } i2c_state_e;

endpackage

// File: rtl/i2c_sync_edge.sv
// rtl/i2c_sync_edge.sv - SCL/SDA synchronizer with edge, START and STOP detection
// Purpose: brings the asynchronous bus lines into clk, then derives bus events
//          from one extra history stage.
// Ports:
//   clk, rst_n         system clock, async active-low reset
//   scl_i, sda_i       raw bus levels
//   sda_s              synchronized SDA level
//   scl_rise, scl_fall one-cycle pulses on synchronized SCL edges
//   start, stop        one-cycle pulses on SDA fall/rise while SCL is high
module i2c_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  // [0],[1]: two-flop synchronizer; [2]: previous synchronized value
  logic [2:0] scl_q;
  logic [2:0] sda_q;

  // Reset to the idle bus level so release never fakes an edge or STOP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= {scl_q[1:0], scl_i};
      sda_q <= {sda_q[1:0], sda_i};
    end
  end

  assign sda_s    = sda_q[1];
  assign scl_rise =  scl_q[1] & ~scl_q[2];
  assign scl_fall = ~scl_q[1] &  scl_q[2];
  // SCL must be high in both stages so an SCL edge is never mistaken for START/STOP
  assign start    = scl_q[1] & scl_q[2] &  sda_q[2] & ~sda_q[1];
  assign stop     = scl_q[1] & scl_q[2] & ~sda_q[2] &  sda_q[1];

endmodule

// File: rtl/i2c_target.sv
// rtl/i2c_target.sv - I2C target bridging bus transfers to a register port
// Purpose: 7-bit addressed I2C responder; first written byte sets the register
//          pointer, further written bytes strobe wr_en, reads stream rd_data.
// Ports:
//   clk, rst_n        system clock (>= 20x SCL), async active-low reset
//   scl_i, sda_i      bus levels (asynchronous)
//   sda_oe            1 = pull SDA low, 0 = release
//   wr_en/addr/data   one-cycle register write strobe
//   rd_addr, rd_data  read index (= pointer) and combinational register value
//   busy              addressed from match until STOP or mismatching START
module i2c_target
  import i2c_pkg::*;
#(
  parameter  logic [6:0] TARGET_ADDR = 7'h3C,
  parameter  int         NUM_REGS    = 8,
  localparam int         PTR_W       = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  scl_i,
  input  logic                  sda_i,
  output logic                  sda_oe,
  output logic                  wr_en,
  output logic [PTR_W-1:0]      wr_addr,
  output logic [I2C_BYTE_W-1:0] wr_data,
  output logic [PTR_W-1:0]      rd_addr,
  input  logic [I2C_BYTE_W-1:0] rd_data,
  output logic                  busy
);

  logic sda_s, scl_rise, scl_fall, start, stop;

  i2c_sync_edge u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .scl_i    (scl_i),
    .sda_i    (sda_i),
    .sda_s    (sda_s),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );

  i2c_state_e            state;
  logic [2:0]            bit_cnt;
  logic [I2C_BYTE_W-1:0] shreg;
  logic [PTR_W-1:0]      ptr;
  logic                  first_byte;
  logic                  rw;
  // In ACK states: 0 = waiting for the fall that starts the ACK bit, 1 = driving it.
  // In ST_WAIT_MACK: 1 = controller acked, reload on the next fall.
  logic                  phase;
  logic [I2C_BYTE_W-1:0] rx_byte;

  assign rx_byte = {shreg[I2C_BYTE_W-2:0], sda_s};
  assign rd_addr = ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      ptr        <= '0;
      first_byte <= 1'b0;
      rw         <= 1'b0;
      phase      <= 1'b0;
      sda_oe     <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      busy       <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      if (stop) begin
        state  <= ST_IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else if (start) begin
        // busy is kept: a repeated START to us re-matches, a foreign one clears it
        state   <= ST_ADDR;
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE, ST_IGNORE: ;

          ST_ADDR: if (scl_rise) begin
            shreg   <= rx_byte;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (rx_byte[7:1] == TARGET_ADDR) begin
                state <= ST_ACK_ADDR;
                busy  <= 1'b1;
                rw    <= rx_byte[0];
                phase <= 1'b0;
              end else begin
                state <= ST_IGNORE;
                busy  <= 1'b0;
              end
            end
          end

          ST_ACK_ADDR: if (scl_fall) begin
            if (!phase) begin
              sda_oe <= 1'b1;
              phase  <= 1'b1;
            end else begin
              phase   <= 1'b0;
              bit_cnt <= '0;
              if (rw == I2C_RW_READ) begin
                // First data bit goes out on the same fall that ends the ACK
                shreg  <= rd_data;
                sda_oe <= ~rd_data[7];
                state  <= ST_TX_BYTE;
              end else begin
                sda_oe     <= 1'b0;
                first_byte <= 1'b1;
                state      <= ST_RX_BYTE;
              end
            end
          end

          ST_RX_BYTE: if (scl_rise) begin
            shreg   <= rx_byte;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (first_byte) begin
                ptr        <= rx_byte[PTR_W-1:0];
                first_byte <= 1'b0;
              end else begin
                wr_en   <= 1'b1;
                wr_addr <= ptr;
                wr_data <= rx_byte;
                ptr     <= ptr + 1'b1;
              end
              state <= ST_ACK_RX;
              phase <= 1'b0;
            end
          end

          ST_ACK_RX: if (scl_fall) begin
            if (!phase) begin
              sda_oe <= 1'b1;
              phase  <= 1'b1;
            end else begin
              sda_oe  <= 1'b0;
              phase   <= 1'b0;
              bit_cnt <= '0;
              state   <= ST_RX_BYTE;
            end
          end

          // shreg[7] is the bit on the bus; each fall advances to the next one
          ST_TX_BYTE: if (scl_fall) begin
            if (bit_cnt == 3'd7) begin
              sda_oe <= 1'b0;
              ptr    <= ptr + 1'b1;
              phase  <= 1'b0;
              state  <= ST_WAIT_MACK;
            end else begin
              shreg   <= {shreg[I2C_BYTE_W-2:0], 1'b0};
              sda_oe  <= ~shreg[I2C_BYTE_W-2];
              bit_cnt <= bit_cnt + 3'd1;
            end
          end

          ST_WAIT_MACK: begin
            if (scl_rise) begin
              if (sda_s) state <= ST_IGNORE;
              else       phase <= 1'b1;
            end else if (scl_fall && phase) begin
              shreg   <= rd_data;
              sda_oe  <= ~rd_data[7];
              bit_cnt <= '0;
              phase   <= 1'b0;
              state   <= ST_TX_BYTE;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// tb/tb_i2c_target.sv - scoreboard bench for i2c_target
`timescale 1ns/1ps
module tb_i2c_target;
  import i2c_pkg::*;

  localparam time Q = 60ns;   // quarter SCL period (6 clk)

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       msda = 1'b1;
  logic       sda_i;
  logic       sda_oe;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic [2:0] rd_addr;
  logic [7:0] rd_data;
  logic       busy;

  always #5 clk = ~clk;

  assign sda_i   = msda & ~sda_oe;
  assign rd_data = 8'h10 + 8'(rd_addr);

  i2c_target dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .scl_i   (scl),
    .sda_i   (sda_i),
    .sda_oe  (sda_oe),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .busy    (busy)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          wr_cnt   = 0;
  int          oe_cnt   = 0;
  logic [10:0] exp_q[$];
  logic [7:0]  rd_q[$];
  logic [10:0] e;
  logic [2:0]  m_ptr = 3'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sda_oe) oe_cnt++;
    if (rst_n && wr_en) begin
      wr_cnt++;
      if (exp_q.size() == 0) check("wr_unexpected", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("wr_addr", wr_addr, e[10:8]);
        check("wr_data", wr_data, e[7:0]);
      end
    end
  end

  task automatic i2c_start();
    msda = 1'b1; #Q; scl = 1'b1; #Q; msda = 1'b0; #Q; scl = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    msda = 1'b0; #Q; scl = 1'b1; #Q; msda = 1'b1; #Q;
  endtask

  task automatic i2c_bit(input logic b, output logic s);
    msda = b; #Q; scl = 1'b1; #Q; s = sda_i; #Q; scl = 1'b0; #Q;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) i2c_bit(b[i], s);
    i2c_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic s;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      i2c_bit(1'b1, s);
      d = {d[6:0], s};
    end
    i2c_bit(nack, s);
  endtask

  // START, 0x78, pointer, n data bytes (MSB-first in d), STOP
  task automatic write_txn(input logic [7:0] p, input logic [23:0] d, input int n);
    logic       ack;
    logic [7:0] b;
    i2c_start();
    send_byte(8'h78, ack);
    check("addr_ack", ack, 0);
    check("busy_on", busy, 1);
    send_byte(p, ack);
    check("ptr_ack", ack, 0);
    m_ptr = p[2:0];
    for (int i = 0; i < n; i++) begin
      b = d[23-8*i -: 8];
      exp_q.push_back({m_ptr, b});
      m_ptr = m_ptr + 3'd1;
      send_byte(b, ack);
      check("data_ack", ack, 0);
    end
    i2c_stop();
    #(2*Q);
    check("busy_off", busy, 0);
    check("wr_pending", exp_q.size(), 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic       ack, s;
    logic [7:0] d;
    int         w0;

    #100;
    check("rst_sda_oe", sda_oe, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    #100;

    // Basic write
    w0 = wr_cnt;
    write_txn(8'h02, 24'hA55A00, 2);
    check("write_cnt", wr_cnt - w0, 2);

    // Read with repeated START
    i2c_start();
    send_byte(8'h78, ack); check("rd_addrw_ack", ack, 0);
    send_byte(8'h05, ack); check("rd_ptr_ack", ack, 0);
    m_ptr = 3'd5;
    i2c_start();
    send_byte(8'h79, ack); check("rd_addrr_ack", ack, 0);
    check("rd_busy", busy, 1);
    for (int i = 0; i < 3; i++) begin
      rd_q.push_back(8'h10 + 8'(m_ptr));
      m_ptr = m_ptr + 3'd1;
      read_byte(i == 2, d);
      check("rd_byte", d, rd_q.pop_front());
    end
    check("rd_release", sda_oe, 0);
    check("rd_state", dut.state, ST_IGNORE);
    check("rd_addr_end", rd_addr, m_ptr);
    i2c_stop();
    #(2*Q);
    check("rd_busy_off", busy, 0);

    // Foreign address: never touches the bus or the register port
    w0 = wr_cnt; oe_cnt = 0;
    i2c_start();
    send_byte(8'hA0, ack); check("fa_nack", ack, 1);
    check("fa_busy", busy, 0);
    send_byte(8'h01, ack); check("fa_d0_nack", ack, 1);
    send_byte(8'hEE, ack); check("fa_d1_nack", ack, 1);
    i2c_stop();
    #(2*Q);
    check("fa_oe_cnt", oe_cnt, 0);
    check("fa_wr_cnt", wr_cnt - w0, 0);
    check("fa_busy_end", busy, 0);

    // Pointer wrap 7 -> 0 -> 1
    w0 = wr_cnt;
    write_txn(8'h07, 24'h112233, 3);
    check("wrap_cnt", wr_cnt - w0, 3);

    // STOP after 4 data bits discards the partial byte
    w0 = wr_cnt;
    i2c_start();
    send_byte(8'h78, ack); check("ps_addr_ack", ack, 0);
    send_byte(8'h03, ack); check("ps_ptr_ack", ack, 0);
    m_ptr = 3'd3;
    i2c_bit(1'b1, s); i2c_bit(1'b0, s); i2c_bit(1'b1, s); i2c_bit(1'b0, s);
    i2c_stop();
    #(2*Q);
    check("ps_wr_cnt", wr_cnt - w0, 0);
    check("ps_state", dut.state, ST_IDLE);
    check("ps_busy", busy, 0);
    write_txn(8'h04, 24'h9C0000, 1);

    // Reset in the middle of the address ACK slot
    i2c_start();
    for (int i = 7; i >= 0; i--) i2c_bit(8'h78 >> i, s);
    msda = 1'b1; #Q; scl = 1'b1; #(Q/2);
    check("ra_ack_driven", sda_oe, 1);
    rst_n = 1'b0;
    #1;
    check("ra_oe_async", sda_oe, 0);
    #(Q/2 - 1ns); scl = 1'b0; #Q;
    rst_n = 1'b1;
    m_ptr = 3'd0;
    #(Q);
    check("ra_ptr", rd_addr, 0);
    check("ra_busy", busy, 0);
    i2c_stop();
    #(2*Q);
    w0 = wr_cnt;
    write_txn(8'h00, 24'hC33C00, 2);
    check("ra_wr_cnt", wr_cnt - w0, 2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
